// File: rtl/data_ram_if.sv
// Data-memory request/response bundle between the CPU data port and the RAM responder.
interface data_ram_if;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        busy;
  logic        error;
  logic [15:0] write_count;
  logic [15:0] read_count;

  modport master (
    output data_address, data_write, data_read, data_writedata,
    input  data_readdata, busy, error, write_count, read_count
  );

  modport slave (
    input  data_address, data_write, data_read, data_writedata,
    output data_readdata, busy, error, write_count, read_count
  );
endinterface

// File: rtl/data_ram_responder.sv
// Word-organised data RAM for the Harvard CPU data port: zero-fills itself after reset,
// serves combinational reads and single-edge writes, flags illegal accesses, counts traffic.
module data_ram_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter logic [31:0] BASE_ADDR = 32'h00000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  data_ram_if.slave  bus
);

  localparam int unsigned          DEPTH    = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_PTR = ADDR_BITS'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_busy;
  logic [ADDR_BITS-1:0]   r_clear_ptr;
  logic [31:0]            r_mem [DEPTH];
  logic                   r_error;
  logic [15:0]            r_write_count;
  logic [15:0]            r_read_count;

  logic [31:0]            w_offset;
  logic                   w_aligned;
  logic                   w_in_range;
  logic                   w_valid;
  logic [ADDR_BITS-1:0]   w_index;
  logic                   w_req;
  logic                   w_wr_ok;
  logic                   w_rd_ok;
  logic                   w_bad_req;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Unsigned wrap of the subtraction makes addresses below BASE_ADDR fall out of range.
  assign w_offset   = bus.data_address - BASE_ADDR;
  assign w_aligned  = (bus.data_address[1:0] == 2'b00);
  assign w_in_range = ({1'b0, w_offset} < (33'd4 << ADDR_BITS));
  assign w_valid    = w_aligned & w_in_range;
  assign w_index    = w_offset[ADDR_BITS+1:2];

  assign w_req     = bus.data_read | bus.data_write;
  assign w_wr_ok   = ~w_busy & bus.data_write & w_valid;
  assign w_rd_ok   = ~w_busy & bus.data_read & w_valid;
  assign w_bad_req = w_req & (w_busy | ~w_valid);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= CLEAR;
    end else if (clk_enable) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      CLEAR: begin
        w_busy = 1'b1;
        if (r_clear_ptr == LAST_PTR) w_state_nxt = READY;
      end
      READY: w_state_nxt = READY;
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clear_ptr   <= '0;
      r_error       <= 1'b0;
      r_write_count <= '0;
      r_read_count  <= '0;
    end else if (clk_enable) begin
      if (w_busy)    r_clear_ptr   <= r_clear_ptr + ADDR_BITS'(1);
      if (w_bad_req) r_error       <= 1'b1;
      if (w_wr_ok)   r_write_count <= sat_inc(r_write_count);
      if (w_rd_ok)   r_read_count  <= sat_inc(r_read_count);
    end
  end

  // The array has no reset of its own; the clear sequencer walks it instead.
  always_ff @(posedge clk) begin
    if (reset && clk_enable) begin
      if (w_busy)       r_mem[r_clear_ptr] <= '0;
      else if (w_wr_ok) r_mem[w_index]     <= bus.data_writedata;
    end
  end

  assign bus.data_readdata = w_rd_ok ? r_mem[w_index] : 32'h0;
  assign bus.busy          = w_busy;
  assign bus.error         = r_error;
  assign bus.write_count   = r_write_count;
  assign bus.read_count    = r_read_count;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_data_ram_responder;

  localparam int SIG_RDATA = 0;
  localparam int SIG_BUSY  = 1;
  localparam int SIG_ERROR = 2;
  localparam int SIG_WCNT  = 3;
  localparam int SIG_RCNT  = 4;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_enable = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   finishing = 1'b0;

  exp_t        sb[$];
  exp_t        m_e;
  logic [31:0] m_act;

  data_ram_if bus ();

  data_ram_responder #(
    .ADDR_BITS(8),
    .BASE_ADDR(32'h00000000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_enable(clk_enable),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    bus.data_write     = w;
    bus.data_read      = r;
    bus.data_address   = a;
    bus.data_writedata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic expect_now(input int sig, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      case (m_e.sig)
        SIG_RDATA: m_act = bus.data_readdata;
        SIG_BUSY:  m_act = {31'b0, bus.busy};
        SIG_ERROR: m_act = {31'b0, bus.error};
        SIG_WCNT:  m_act = {16'b0, bus.write_count};
        SIG_RCNT:  m_act = {16'b0, bus.read_count};
        default:   m_act = 'x;
      endcase
      checks++;
      if (m_act !== m_e.val || m_e.cyc != cyc) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h want=%h (expected at cyc %0d)",
                 m_e.name, cyc, m_act, m_e.val, m_e.cyc);
      end
    end
    if (finishing) begin
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
      end
    end
  end

  initial begin
    idle();
    reset      = 1'b0;
    clk_enable = 1'b1;

    // ---- reset held for two edges, then the full clear ----
    step();
    step();
    expect_now(SIG_BUSY,  32'd1, "rst_busy");
    expect_now(SIG_ERROR, 32'd0, "rst_error");
    expect_now(SIG_WCNT,  32'd0, "rst_wcnt");
    expect_now(SIG_RCNT,  32'd0, "rst_rcnt");
    expect_now(SIG_RDATA, 32'd0, "rst_rdata");
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      expect_now(SIG_BUSY, 32'd1, "clear_busy");
      step();
    end
    expect_now(SIG_BUSY,  32'd0, "clear_done");
    expect_now(SIG_ERROR, 32'd0, "clear_error");

    drive(1'b0, 1'b1, 32'h0, 32'h0);
    expect_now(SIG_RDATA, 32'h0, "zero_rd_0x0");
    step();
    drive(1'b0, 1'b1, 32'h4, 32'h0);
    expect_now(SIG_RDATA, 32'h0, "zero_rd_0x4");
    step();
    drive(1'b0, 1'b1, 32'h3FC, 32'h0);
    expect_now(SIG_RDATA, 32'h0, "zero_rd_0x3fc");
    step();
    idle();
    expect_now(SIG_ERROR, 32'd0, "zero_rd_error");
    expect_now(SIG_RCNT,  32'd3, "zero_rd_rcnt");
    expect_now(SIG_WCNT,  32'd0, "zero_rd_wcnt");

    // ---- write then read ----
    drive(1'b1, 1'b0, 32'h8, 32'h00000054);
    step();
    drive(1'b0, 1'b1, 32'h8, 32'h0);
    expect_now(SIG_RDATA, 32'h00000054, "raw_rdata");
    expect_now(SIG_WCNT,  32'd1, "raw_wcnt");
    step();
    idle();
    expect_now(SIG_WCNT, 32'd1, "raw_wcnt_after");
    expect_now(SIG_RCNT, 32'd4, "raw_rcnt_after");

    // ---- simultaneous read and write ----
    drive(1'b1, 1'b0, 32'h8, 32'h00000011);
    step();
    drive(1'b1, 1'b1, 32'h8, 32'h00000022);
    expect_now(SIG_RDATA, 32'h00000011, "rw_old_data");
    expect_now(SIG_WCNT,  32'd2, "rw_wcnt_before");
    expect_now(SIG_RCNT,  32'd4, "rw_rcnt_before");
    step();
    drive(1'b0, 1'b1, 32'h8, 32'h0);
    expect_now(SIG_RDATA, 32'h00000022, "rw_new_data");
    expect_now(SIG_WCNT,  32'd3, "rw_wcnt_after");
    expect_now(SIG_RCNT,  32'd5, "rw_rcnt_after");
    step();

    // ---- clk_enable low freezes state; read path stays live ----
    clk_enable = 1'b0;
    drive(1'b1, 1'b1, 32'h8, 32'h00000099);
    expect_now(SIG_RDATA, 32'h00000022, "en0_rdata");
    step();
    step();
    clk_enable = 1'b1;
    drive(1'b0, 1'b1, 32'h8, 32'h0);
    expect_now(SIG_RDATA, 32'h00000022, "en0_mem_frozen");
    expect_now(SIG_WCNT,  32'd3, "en0_wcnt_frozen");
    expect_now(SIG_RCNT,  32'd6, "en0_rcnt_frozen");
    step();

    // ---- out-of-range read ----
    drive(1'b0, 1'b1, 32'h400, 32'h0);
    expect_now(SIG_RDATA, 32'h0, "oor_rdata");
    expect_now(SIG_ERROR, 32'd0, "oor_error_before");
    step();
    idle();
    expect_now(SIG_ERROR, 32'd1, "oor_error");
    expect_now(SIG_RCNT,  32'd7, "oor_rcnt");
    step();
    expect_now(SIG_ERROR, 32'd1, "oor_error_sticky");

    // ---- reset, partial clear, reset mid-clear ----
    reset = 1'b0;
    step();
    expect_now(SIG_ERROR, 32'd0, "rst2_error");
    expect_now(SIG_WCNT,  32'd0, "rst2_wcnt");
    expect_now(SIG_RCNT,  32'd0, "rst2_rcnt");
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      expect_now(SIG_BUSY, 32'd1, "part_clear_busy");
      step();
    end
    reset = 1'b0;
    step();
    reset = 1'b1;

    // ---- restarted clear with a 10-cycle enable gap and an ignored request ----
    for (int i = 0; i < 266; i++) begin
      clk_enable = (i >= 50 && i < 60) ? 1'b0 : 1'b1;
      if (i == 20) begin
        drive(1'b1, 1'b0, 32'h8, 32'h000000AB);
        expect_now(SIG_ERROR, 32'd0, "clr_req_error_before");
      end else begin
        idle();
      end
      if (i == 21) begin
        expect_now(SIG_ERROR, 32'd1, "clr_req_error");
        expect_now(SIG_WCNT,  32'd0, "clr_req_wcnt");
      end
      expect_now(SIG_BUSY, 32'd1, "restart_busy");
      step();
    end
    clk_enable = 1'b1;
    expect_now(SIG_BUSY, 32'd0, "restart_done");
    drive(1'b0, 1'b1, 32'h8, 32'h0);
    expect_now(SIG_RDATA, 32'h0, "clr_req_ignored");
    expect_now(SIG_ERROR, 32'd1, "clr_req_error_sticky");
    step();

    // ---- fresh clear, misaligned write ----
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) expect_now(SIG_BUSY, 32'd1, "c3_busy_last");
      step();
    end
    expect_now(SIG_BUSY,  32'd0, "c3_done");
    expect_now(SIG_ERROR, 32'd0, "mis_error_before");
    drive(1'b1, 1'b0, 32'h5, 32'hDEADBEEF);
    step();
    drive(1'b0, 1'b1, 32'h4, 32'h0);
    expect_now(SIG_RDATA, 32'h0, "mis_word1");
    expect_now(SIG_ERROR, 32'd1, "mis_error");
    expect_now(SIG_WCNT,  32'd0, "mis_wcnt");
    step();
    idle();
    expect_now(SIG_RCNT,  32'd1, "mis_rcnt");
    step();
    expect_now(SIG_ERROR, 32'd1, "mis_error_sticky");

    // ---- write counter saturation ----
    for (int i = 0; i < 65540; i++) begin
      drive(1'b1, 1'b0, {22'b0, 8'(i % 256), 2'b00}, 32'(i));
      if (i == 65534) expect_now(SIG_WCNT, 32'h0000FFFE, "sat_wcnt_fffe");
      if (i == 65535) expect_now(SIG_WCNT, 32'h0000FFFF, "sat_wcnt_ffff");
      step();
    end
    drive(1'b0, 1'b1, 32'hC, 32'h0);
    expect_now(SIG_WCNT,  32'h0000FFFF, "sat_wcnt_held");
    expect_now(SIG_RDATA, 32'h00010003, "sat_last_data");
    step();
    idle();
    expect_now(SIG_RCNT, 32'd2, "sat_rcnt");

    finishing = 1'b1;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
